mult_div_unit: RTL
==================

# mult_div_unit

Iterative signed multiply/divide unit for the multicycle MIPS datapath, producing the HI/LO register pair for `mult` and `div`. It sits downstream of the control unit, which issues a one-cycle start pulse with operands taken from the A/B registers and then waits on `Busy`/`Done` before leaving the R-type sequence. It uses a radix-2 shift-add multiplier and a restoring divider over magnitudes, with a final sign-fix cycle. It owns HI and LO; `mfhi`/`mflo` read the `Hi`/`Lo` outputs directly.

## Interface
No parameters; the width is fixed at 32 bits.

- `Clk` in 1: single clock; all state changes on the rising edge.
- `Reset` in 1: reset is synchronous and active-low; it takes effect on the rising `Clk` edge while low.
- `A` in 32: operand 1 (multiplicand or dividend), two's complement.
- `B` in 32: operand 2 (multiplier or divisor), two's complement.
- `MultStart` in 1: start a signed multiply; sampled only in IDLE.
- `DivStart` in 1: start a signed divide; sampled only in IDLE.
- `Hi` out 32: HI register.
- `Lo` out 32: LO register.
- `Busy` out 1: an operation is in progress (MULT, DIV, FIX states).
- `Done` out 1: one-cycle completion pulse (DONE state).
- `DivZero` out 1: registered flag, set when the last divide had `B`==0.

## Operation
- States and transitions:
  - IDLE -> MULT when `MultStart`=1.
  - IDLE -> DIV when `DivStart`=1 and `B`!=0.
  - IDLE -> DONE when `DivStart`=1 and `B`==0.
  - MULT/DIV -> FIX after 32 iterations.
  - FIX -> DONE.
  - DONE -> IDLE.
- Simultaneous `MultStart` and `DivStart`: multiply wins; the divide request is dropped.
- Starts outside IDLE are ignored, with no queuing.
- Capture on the start edge:
  - |A| and |B| as 32-bit unsigned magnitudes; |0x80000000| = 0x80000000.
  - Result sign: sA XOR sB.
  - Remainder sign: sA.
- MULT iteration, 32 cycles, with a 6-bit counter counting 0..31:
  - If the product LSB is 1, add the magnitude multiplicand into the upper half using a 33-bit sum.
  - Then shift the 65-bit {carry, product} right by 1.
- DIV iteration, 32 cycles, restoring:
  - Shift {rem, quot} left by 1.
  - Compute trial = rem − |B| at 33 bits.
  - If trial is non-negative: rem = trial and quot LSB = 1.
- FIX:
  - Multiply: negate the 64-bit magnitude if the result sign is 1, then write {Hi, Lo} = product.
  - Divide: Lo = quotient, negated if the result sign is 1; Hi = remainder, negated if sA is 1. This gives truncation toward zero.
  - 0x80000000 / 0xFFFFFFFF yields Lo = 0x80000000, Hi = 0, with no trap.
- `DivZero`:
  - Divide by zero leaves Hi/Lo unchanged and sets `DivZero`=1.
  - Any accepted start clears `DivZero` before completion. A divide-by-zero start clears and sets it in one edge, leaving it at 1.
- `Hi`/`Lo` change only on the FIX->DONE edge and on reset.
- Reset values: state IDLE; `Hi`=0, `Lo`=0, `Busy`=0, `Done`=0, `DivZero`=0; counter 0. Reset mid-operation aborts the operation and clears Hi/Lo.

## Timing
- Start sampled at edge 0 (cycle 0 is IDLE with start high).
- Cycles 1–32: MULT or DIV, `Busy`=1.
- Cycle 33: FIX, `Busy`=1; Hi/Lo are written at the end of cycle 33.
- Cycle 34: DONE, `Done`=1, `Busy`=0, new Hi/Lo visible.
- Cycle 35: IDLE; a new start is accepted in cycle 35, not cycle 34.
- Total latency: start to `Done` is 34 cycles.
- Divide by zero: start at edge 0, `Done`=1 in cycle 1, IDLE in cycle 2.
- `A`/`B` may change any time after the start edge; the results use the captured values.
- `Busy` and `Done` are never high together.
- `Done` is exactly one cycle wide.

## Test plan
- Multiply 7 × 0xFFFFFFFD (−3) -> in cycle 34: `Done`=1, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; `Busy` high in cycles 1–33.
- Multiply 0x80000000 × 0x80000000 -> Hi=0x40000000, Lo=0x00000000; multiply 0xFFFFFFFF × 0xFFFFFFFF -> Hi=0, Lo=1.
- Divide 0xFFFFFFF9 (−7) / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Divide 7 / 0xFFFFFFFE -> Lo=0xFFFFFFFD, Hi=1. Divide 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Divide 5 / 0 after a prior multiply left Hi=0x12, Lo=0x34 -> `Done` in cycle 1, `DivZero`=1, Hi/Lo unchanged. A following multiply 2×3 clears `DivZero` at its start edge and gives Lo=6.
- Protocol:
  - `DivStart` pulsed in cycle 10 of a multiply is ignored, and the multiply result is correct.
  - `MultStart` and `DivStart` together -> multiply is performed.
  - A start in the DONE cycle is ignored.
- `Reset` driven low in cycle 15 of a divide -> next cycle: IDLE, Hi=Lo=0, `Busy`=`Done`=`DivZero`=0. A fresh multiply 3×4 then gives Lo=12 at its cycle 34.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// ============================================================================
// mult_div_unit_if : operand/start/result bundle between control and HI/LO unit
// Revision 1.0
// ============================================================================
`default_nettype none

interface mult_div_unit_if;
  logic [31:0] A;
  logic [31:0] B;
  logic        MultStart;
  logic        DivStart;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;
  logic        DivZero;

  modport master (
    output A, B, MultStart, DivStart,
    input  Hi, Lo, Busy, Done, DivZero
  );

  modport slave (
    input  A, B, MultStart, DivStart,
    output Hi, Lo, Busy, Done, DivZero
  );
endinterface

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit : iterative signed 32x32 multiply / 32/32 divide owning HI/LO
// Revision 1.0
// ============================================================================
`default_nettype none

module mult_div_unit (
  input  logic           Clk,
  input  logic           Reset,
  mult_div_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic        is_div_q, is_div_d;
  logic        rsign_q, rsign_d;
  logic        remsign_q, remsign_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        divzero_q, divzero_d;

  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_sum;
  logic [32:0] w_trial;
  logic [63:0] w_prod;

  // Negating 0x80000000 wraps to itself, which is the correct unsigned magnitude
  assign w_abs_a = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
  assign w_abs_b = bus.B[31] ? (~bus.B + 32'd1) : bus.B;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    is_div_d  = is_div_q;
    rsign_d   = rsign_q;
    remsign_d = remsign_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    divzero_d = divzero_q;
    w_sum     = 33'd0;
    w_trial   = 33'd0;
    w_prod    = 64'd0;

    case (state_q)
      S_IDLE: begin
        if (bus.MultStart) begin
          state_d   = S_MULT;
          cnt_d     = 6'd0;
          is_div_d  = 1'b0;
          opnd_d    = w_abs_a;
          acc_d     = {32'd0, w_abs_b};
          rsign_d   = bus.A[31] ^ bus.B[31];
          remsign_d = bus.A[31];
          divzero_d = 1'b0;
        end else if (bus.DivStart) begin
          cnt_d     = 6'd0;
          is_div_d  = 1'b1;
          opnd_d    = w_abs_b;
          acc_d     = {32'd0, w_abs_a};
          rsign_d   = bus.A[31] ^ bus.B[31];
          remsign_d = bus.A[31];
          if (bus.B == 32'd0) begin
            state_d   = S_DONE;
            divzero_d = 1'b1;
          end else begin
            state_d   = S_DIV;
            divzero_d = 1'b0;
          end
        end
      end

      S_MULT: begin
        w_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        acc_d = {w_sum, acc_q[31:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_FIX;
        end
      end

      S_DIV: begin
        // Remainder is always below the divisor, so acc_q[63] is zero and drops out of the shift
        w_trial = {1'b0, acc_q[62:31]} - {1'b0, opnd_q};
        if (!w_trial[32]) begin
          acc_d = {w_trial[31:0], acc_q[30:0], 1'b1};
        end else begin
          acc_d = {acc_q[62:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (is_div_q) begin
          lo_d = rsign_q   ? (~acc_q[31:0]  + 32'd1) : acc_q[31:0];
          hi_d = remsign_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        end else begin
          w_prod = rsign_q ? (~acc_q + 64'd1) : acc_q;
          hi_d   = w_prod[63:32];
          lo_d   = w_prod[31:0];
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      opnd_q    <= 32'd0;
      acc_q     <= 64'd0;
      is_div_q  <= 1'b0;
      rsign_q   <= 1'b0;
      remsign_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      is_div_q  <= is_div_d;
      rsign_q   <= rsign_d;
      remsign_q <= remsign_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      divzero_q <= divzero_d;
    end
  end

  assign bus.Hi      = hi_q;
  assign bus.Lo      = lo_q;
  assign bus.Busy    = (state_q == S_MULT) || (state_q == S_DIV) || (state_q == S_FIX);
  assign bus.Done    = (state_q == S_DONE);
  assign bus.DivZero = divzero_q;

endmodule

`default_nettype wire
